schmitt_sched: RTL

Time-multiplexed hysteresis engine that shares one threshold-compare datapath among NCH sampled channels. It arbitrates sample requests round-robin and applies the Schmitt decision (high/low threshold with hold band) per channel. It keeps one state bit per channel and reports each decision on an event port. It sits between the sensor sample front-ends and the downstream event/interrupt logic, and replaces per-channel 1-bit trigger instances.

---
 rtl/schmitt_sched.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/schmitt_sched.sv
// Time-multiplexed Schmitt-trigger engine: round-robin sample arbiter, two-stage compare pipeline, per-channel state.
// Optional build macro SCHMITT_EVT_FILTER_EN: when defined, only state-changing decisions raise evt_valid.
module schmitt_sched #(
    parameter int              NCH    = 4,
    parameter int              DW     = 8,
    parameter logic [DW-1:0]   HI_RST = 8'hC0,
    parameter logic [DW-1:0]   LO_RST = 8'h40,
    localparam int             CW     = $clog2(NCH)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NCH-1:0]      samp_valid,
    input  logic [NCH*DW-1:0]   samp_data,
    output logic [NCH-1:0]      samp_ready,
    input  logic                cfg_we,
    input  logic [DW-1:0]       cfg_hi,
    input  logic [DW-1:0]       cfg_lo,
    output logic                cfg_err,
    output logic [NCH-1:0]      state_out,
    output logic                evt_valid,
    output logic [CW-1:0]       evt_ch,
    output logic                evt_level,
    output logic                evt_changed
);

    function automatic logic schmitt_next(input logic [DW-1:0] d, input logic [DW-1:0] hi,
                                          input logic [DW-1:0] lo, input logic old);
        if (d >= hi) begin
            return 1'b1;
        end else if (d <= lo) begin
            return 1'b0;
        end else begin
            return old;
        end
    endfunction

    logic [CW-1:0]  rr_ptr_q,  rr_ptr_d;
    logic           s1_vld_q,  s1_vld_d;
    logic [CW-1:0]  s1_ch_q,   s1_ch_d;
    logic [DW-1:0]  s1_data_q, s1_data_d;
    logic [DW-1:0]  hi_q,      hi_d;
    logic [DW-1:0]  lo_q,      lo_d;
    logic [NCH-1:0] state_q,   state_d;
    logic           cfg_err_q, cfg_err_d;
    logic           evt_valid_q, evt_valid_d;
    logic [CW-1:0]  evt_ch_q,  evt_ch_d;
    logic           evt_level_q, evt_level_d;
    logic           evt_changed_q, evt_changed_d;

    logic           gnt_any_s;
    logic [CW-1:0]  gnt_idx_s;
    logic [NCH-1:0] gnt_s;
    logic [DW-1:0]  gnt_data_s;
    logic           old_lvl_s;
    logic           new_lvl_s;
    logic           chg_s;

    // Round-robin grant: first requester after rr_ptr, wrapping; masked while in reset.
    always_comb begin
        logic [CW-1:0] cand_v;
        cand_v     = '0;
        gnt_any_s  = 1'b0;
        gnt_idx_s  = '0;
        gnt_s      = '0;
        gnt_data_s = '0;
        for (int k = 1; k <= NCH; k++) begin
            cand_v = CW'((int'(rr_ptr_q) + k) % NCH);
            if (!gnt_any_s && samp_valid[cand_v]) begin
                gnt_any_s = 1'b1;
                gnt_idx_s = cand_v;
            end else begin
                gnt_any_s = gnt_any_s;
            end
        end
        for (int i = 0; i < NCH; i++) begin
            if (gnt_any_s && (gnt_idx_s == CW'(i))) begin
                gnt_s[i]   = 1'b1;
                gnt_data_s = samp_data[i*DW +: DW];
            end else begin
                gnt_s[i]   = 1'b0;
            end
        end
        if (reset_n) begin
            samp_ready = gnt_s;
        end else begin
            samp_ready = '0;
        end
    end

    // Next-state logic: S1 capture, S2 hysteresis decision, threshold config and event formation.
    always_comb begin
        rr_ptr_d      = rr_ptr_q;
        s1_vld_d      = gnt_any_s;
        s1_ch_d       = s1_ch_q;
        s1_data_d     = s1_data_q;
        hi_d          = hi_q;
        lo_d          = lo_q;
        state_d       = state_q;
        cfg_err_d     = 1'b0;
        evt_ch_d      = evt_ch_q;
        evt_level_d   = evt_level_q;
        old_lvl_s     = state_q[s1_ch_q];
        new_lvl_s     = schmitt_next(s1_data_q, hi_q, lo_q, old_lvl_s);
        chg_s         = new_lvl_s ^ old_lvl_s;
        evt_changed_d = s1_vld_q & chg_s;
`ifdef SCHMITT_EVT_FILTER_EN
        evt_valid_d   = s1_vld_q & chg_s;
`else
        evt_valid_d   = s1_vld_q;
`endif

        if (gnt_any_s) begin
            rr_ptr_d  = gnt_idx_s;
            s1_ch_d   = gnt_idx_s;
            s1_data_d = gnt_data_s;
        end else begin
            rr_ptr_d  = rr_ptr_q;
        end

        // Same-channel samples back-to-back are safe: state is only touched here in S2.
        if (s1_vld_q) begin
            state_d[s1_ch_q] = new_lvl_s;
            evt_ch_d         = s1_ch_q;
            evt_level_d      = new_lvl_s;
        end else begin
            state_d          = state_q;
        end

        if (cfg_we && (cfg_hi > cfg_lo)) begin
            hi_d = cfg_hi;
            lo_d = cfg_lo;
        end else if (cfg_we) begin
            cfg_err_d = 1'b1;
        end else begin
            cfg_err_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q      <= CW'(NCH - 1);
            s1_vld_q      <= 1'b0;
            s1_ch_q       <= '0;
            s1_data_q     <= '0;
            hi_q          <= HI_RST;
            lo_q          <= LO_RST;
            state_q       <= '0;
            cfg_err_q     <= 1'b0;
            evt_valid_q   <= 1'b0;
            evt_ch_q      <= '0;
            evt_level_q   <= 1'b0;
            evt_changed_q <= 1'b0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            s1_vld_q      <= s1_vld_d;
            s1_ch_q       <= s1_ch_d;
            s1_data_q     <= s1_data_d;
            hi_q          <= hi_d;
            lo_q          <= lo_d;
            state_q       <= state_d;
            cfg_err_q     <= cfg_err_d;
            evt_valid_q   <= evt_valid_d;
            evt_ch_q      <= evt_ch_d;
            evt_level_q   <= evt_level_d;
            evt_changed_q <= evt_changed_d;
        end
    end

    assign state_out   = state_q;
    assign cfg_err     = cfg_err_q;
    assign evt_valid   = evt_valid_q;
    assign evt_ch      = evt_ch_q;
    assign evt_level   = evt_level_q;
    assign evt_changed = evt_changed_q;

endmodule
